// File: rtl/stack_seq_ctrl.sv
// Stack command sequencer: accepts one operation per handshake, drives the
// single-port synchronous stack RAM and keeps the top-of-stack cached in tos.
module stack_seq_ctrl #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             mem_we,
  output logic             mem_re,
  output logic [PTR_W-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             error
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_B
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_PUSH  = 3'b001,
    OP_POP   = 3'b010,
    OP_PEEK  = 3'b011,
    OP_DUP   = 3'b100,
    OP_SWAP  = 3'b101,
    OP_ADD   = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  state_e             state_q, state_n;
  op_e                op_q, op_n;
  op_e                cmd_op_e;
  logic [CNT_W-1:0]   count_q, count_n;
  logic [WIDTH-1:0]   tos_q, tos_n;
  logic [WIDTH-1:0]   out_data_q, out_data_n;
  logic               out_valid_q, out_valid_n;
  logic               error_q, error_n;
  logic [PTR_W-1:0]   addr_q, addr_c;
  logic [WIDTH-1:0]   wdata_q, wdata_c;
  logic               we_c, re_c;
  logic               accept;
  logic               is_full, is_empty;
  logic [PTR_W-1:0]   addr_top, addr_below;
  logic [WIDTH-1:0]   sum;

  assign cmd_op_e   = op_e'(cmd_op);
  assign cmd_ready  = ena & (state_q == IDLE);
  // Strobes are issued in the accept cycle so read data lands in RD_WAIT;
  // rst_n gating keeps them quiet while reset is held.
  assign accept     = rst_n & cmd_valid & cmd_ready;
  assign is_full    = (count_q == CNT_FULL);
  assign is_empty   = (count_q == '0);
  assign addr_top   = PTR_W'(count_q - CNT_ONE);
  assign addr_below = PTR_W'(count_q - CNT_TWO);
  assign sum        = mem_rdata + tos_q;

  always_comb begin
    state_n     = state_q;
    op_n        = op_q;
    count_n     = count_q;
    tos_n       = tos_q;
    out_data_n  = out_data_q;
    out_valid_n = 1'b0;
    error_n     = 1'b0;
    we_c        = 1'b0;
    re_c        = 1'b0;
    addr_c      = addr_q;
    wdata_c     = wdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_n = cmd_op_e;
          case (cmd_op_e)
            OP_NOP: ;
            OP_PUSH: begin
              if (is_full) begin
                error_n = 1'b1;
              end else begin
                we_c    = 1'b1;
                addr_c  = count_q[PTR_W-1:0];
                wdata_c = cmd_data;
                tos_n   = cmd_data;
                count_n = count_q + CNT_ONE;
              end
            end
            OP_POP: begin
              if (is_empty) begin
                error_n = 1'b1;
              end else begin
                out_data_n  = tos_q;
                out_valid_n = 1'b1;
                count_n     = count_q - CNT_ONE;
                if (count_q > CNT_ONE) begin
                  re_c    = 1'b1;
                  addr_c  = addr_below;
                  state_n = RD_WAIT;
                end else begin
                  tos_n = '0;
                end
              end
            end
            OP_PEEK: begin
              if (is_empty) begin
                error_n = 1'b1;
              end else begin
                out_data_n  = tos_q;
                out_valid_n = 1'b1;
              end
            end
            OP_DUP: begin
              if (is_empty || is_full) begin
                error_n = 1'b1;
              end else begin
                we_c    = 1'b1;
                addr_c  = count_q[PTR_W-1:0];
                wdata_c = tos_q;
                count_n = count_q + CNT_ONE;
              end
            end
            OP_SWAP, OP_ADD: begin
              if (count_q < CNT_TWO) begin
                error_n = 1'b1;
              end else begin
                re_c    = 1'b1;
                addr_c  = addr_below;
                state_n = RD_WAIT;
              end
            end
            OP_CLEAR: begin
              count_n = '0;
              tos_n   = '0;
            end
            default: ;
          endcase
        end
      end

      RD_WAIT: begin
        case (op_q)
          OP_POP: begin
            tos_n   = mem_rdata;
            state_n = IDLE;
          end
          OP_SWAP: begin
            we_c    = 1'b1;
            addr_c  = addr_below;
            wdata_c = tos_q;
            tos_n   = mem_rdata;
            state_n = WR_B;
          end
          OP_ADD: begin
            we_c    = 1'b1;
            addr_c  = addr_below;
            wdata_c = sum;
            tos_n   = sum;
            count_n = count_q - CNT_ONE;
            state_n = IDLE;
          end
          default: state_n = IDLE;
        endcase
      end

      WR_B: begin
        we_c    = 1'b1;
        addr_c  = addr_top;
        wdata_c = tos_q;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_NOP;
      count_q     <= '0;
      tos_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_n;
      op_q        <= op_n;
      count_q     <= count_n;
      tos_q       <= tos_n;
      out_data_q  <= out_data_n;
      out_valid_q <= out_valid_n;
      error_q     <= error_n;
      addr_q      <= addr_c;
      wdata_q     <= wdata_c;
    end
  end

  assign mem_we    = we_c;
  assign mem_re    = re_c;
  assign mem_addr  = addr_c;
  assign mem_wdata = wdata_c;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign error     = error_q;
  assign count     = count_q;
  assign full      = is_full;
  assign empty     = is_empty;

endmodule
